// File: rtl/lut_sched_pkg.sv
// lut_sched_pkg: shared state encoding and LUT geometry for the LUT evaluation scheduler.
package lut_sched_pkg;
   localparam int LUT_BITS = 16;
   localparam int LUT_AW = 4;
   typedef enum logic [2:0] {IDLE, LOAD, VERIFY, EVAL, RESP} lut_sched_state_t;
endpackage

// File: rtl/lut_cell.sv
// lut_cell: serially loaded 4-input LUT, MSB shifted in first so bit k ends up at sr_q[k].
module lut_cell
   import lut_sched_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              shift_en,
   input  logic              shift_in,
   input  logic [LUT_AW-1:0] addr,
   output logic              dout
);
   logic [LUT_BITS-1:0] sr_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else if (shift_en) sr_q <= {sr_q[LUT_BITS-2:0], shift_in};
   end
   assign dout = sr_q[addr];
endmodule

// File: rtl/lut_eval_scheduler.sv
// lut_eval_scheduler: round-robin time-sharing of one serially configured LUT cell.
// Define LUT_SCHED_READBACK_EN to add a post-load readback sweep that drives resp_err.
module lut_eval_scheduler
   import lut_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int NCFG = 4,
   localparam int CW = $clog2(NCFG),
   localparam int IW = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_we,
   input  logic [CW-1:0]      cfg_sel,
   input  logic [15:0]        cfg_data,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [4*NREQ-1:0]  req_addr,
   input  logic [CW*NREQ-1:0] req_cfg,
   output logic [NREQ-1:0]    req_ready,
   output logic               resp_valid,
   output logic [IW-1:0]      resp_id,
   output logic               resp_result,
   output logic               resp_err
);
   lut_sched_state_t state_q, state_d;
   logic [LUT_BITS-1:0] cfg_q [NCFG];
   logic [IW-1:0] rr_q, rr_d, id_q, id_d, resp_id_q, resp_id_d, gnt_id, idx;
   logic [LUT_AW-1:0] addr_q, addr_d, cnt_q, cnt_d, lut_addr;
   logic [CW-1:0] slot_q, slot_d, loaded_cfg_q, loaded_cfg_d, req_slot;
   logic loaded_valid_q, loaded_valid_d, err_q, err_d;
   logic resp_result_q, resp_result_d, resp_err_q, resp_err_d;
   logic found, lut_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) for (int i = 0; i < NCFG; i++) cfg_q[i] <= '0;
      else if (cfg_we) cfg_q[cfg_sel] <= cfg_data;
   end

   lut_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (state_q == LOAD),
      .shift_in (cfg_q[slot_q][~cnt_q]),
      .addr     (lut_addr),
      .dout     (lut_dout)
   );

   assign lut_addr = (state_q == VERIFY) ? cnt_q : addr_q;
   assign req_slot = req_cfg[CW*gnt_id +: CW];
   // Gated by rst_n so every output reads 0 while reset is held.
   assign req_ready = (rst_n && state_q == IDLE && found) ? NREQ'(1) << gnt_id : '0;
   assign resp_valid = (state_q == RESP);
   assign resp_id = resp_id_q;
   assign resp_result = resp_result_q;
   assign resp_err = resp_err_q;

   always_comb begin
      state_d = state_q;
      rr_d = rr_q;
      id_d = id_q;
      addr_d = addr_q;
      slot_d = slot_q;
      cnt_d = cnt_q;
      loaded_cfg_d = loaded_cfg_q;
      loaded_valid_d = loaded_valid_q;
      err_d = err_q;
      resp_id_d = resp_id_q;
      resp_result_d = resp_result_q;
      resp_err_d = resp_err_q;
      found = 1'b0;
      gnt_id = '0;
      idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IW'((int'(rr_q) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gnt_id = idx;
         end
      end
      // LOAD overwrites the cell anyway, so only other states invalidate residency.
      if (cfg_we && cfg_sel == loaded_cfg_q && state_q != LOAD) loaded_valid_d = 1'b0;
      case (state_q)
         IDLE: if (found) begin
            id_d = gnt_id;
            addr_d = req_addr[4*gnt_id +: 4];
            slot_d = req_slot;
            rr_d = gnt_id;
            cnt_d = '0;
            err_d = 1'b0;
            if (loaded_valid_q && loaded_cfg_q == req_slot) state_d = EVAL;
            else begin
               state_d = LOAD;
               loaded_valid_d = 1'b0;
            end
         end
         LOAD: begin
            cnt_d = cnt_q + 4'd1;
            if (cfg_we && cfg_sel == slot_q) cnt_d = '0;
            else if (cnt_q == 4'hF) begin
               loaded_cfg_d = slot_q;
               loaded_valid_d = 1'b1;
`ifdef LUT_SCHED_READBACK_EN
               state_d = VERIFY;
`else
               state_d = EVAL;
`endif
            end
         end
`ifdef LUT_SCHED_READBACK_EN
         VERIFY: begin
            cnt_d = cnt_q + 4'd1;
            err_d = err_q | (lut_dout != cfg_q[slot_q][cnt_q]);
            if (cnt_q == 4'hF) begin
               state_d = EVAL;
               if (err_d) loaded_valid_d = 1'b0;
            end
         end
`endif
         EVAL: begin
            resp_result_d = lut_dout;
            resp_id_d = id_q;
            resp_err_d = err_q;
            state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q <= IW'(NREQ - 1);
         id_q <= '0;
         addr_q <= '0;
         slot_q <= '0;
         cnt_q <= '0;
         loaded_cfg_q <= '0;
         loaded_valid_q <= 1'b0;
         err_q <= 1'b0;
         resp_id_q <= '0;
         resp_result_q <= 1'b0;
         resp_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q <= rr_d;
         id_q <= id_d;
         addr_q <= addr_d;
         slot_q <= slot_d;
         cnt_q <= cnt_d;
         loaded_cfg_q <= loaded_cfg_d;
         loaded_valid_q <= loaded_valid_d;
         err_q <= err_d;
         resp_id_q <= resp_id_d;
         resp_result_q <= resp_result_d;
         resp_err_q <= resp_err_d;
      end
   end
endmodule

// File: doc/lut_eval_scheduler.md
# lut_eval_scheduler

Shares a single serially-configured 4-input LUT cell between `NREQ` requesters. Each request names a truth-table slot and a 4-bit address. The scheduler arbitrates round-robin and reloads the LUT from the slot's stored truth table only when that slot is not already resident. It then evaluates the address and returns a one-bit result tagged with the requester id. It sits between the LUT primitives (`and2`/`and4`/equation-style LUTs) and the logic that needs time-shared evaluation of programmable 4-input functions.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `NCFG`, 4: number of stored truth-table slots (power of 2, ≥2); `CW` = clog2(`NCFG`).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: write one truth-table slot this cycle.
- `cfg_sel` in `CW`: slot to write.
- `cfg_data` in 16: truth table; bit k = result for address k.
- `req_valid` in `NREQ`: per-requester request.
- `req_addr` in 4*`NREQ`: address, requester i at [4i+3:4i].
- `req_cfg` in `CW`*`NREQ`: slot id, requester i at [CW*i +: CW].
- `req_ready` out `NREQ`: one-hot, high in the cycle requester i is accepted.
- `resp_valid` out 1: one-cycle result pulse.
- `resp_id` out clog2(`NREQ`): requester that owns the response.
- `resp_result` out 1: LUT output for the captured address.
- `resp_err` out 1: readback mismatch; 0 unless `LUT_SCHED_READBACK_EN` is defined.

## Operation
- **Slot storage.** `NCFG` × 16-bit registers, all 0 at reset. A write in any state takes effect at the next edge.
- **Residency tracking.** `loaded_cfg` (reset 0) and `loaded_valid` (reset 0) record which slot the LUT holds.
- **FSM states:** IDLE, LOAD, VERIFY (macro only), EVAL, RESP. Reset state is IDLE.
- **IDLE.**
  - If any `req_valid` is high, grant the first requester at or after `rr_ptr`+1, modulo `NREQ`. `rr_ptr` resets to `NREQ`-1, so requester 0 has first priority.
  - `req_ready[g]` is combinational, high only in IDLE. A request is accepted when `req_valid[g]` and `req_ready[g]` are both high.
  - On acceptance, capture the id, address and slot, and set `rr_ptr` ← g.
  - Go to EVAL if `loaded_valid` is set and `loaded_cfg` equals the slot (a hit); otherwise go to LOAD (a miss).
- **LOAD.**
  - Shift the slot's 16 bits into the LUT cell, MSB first, one bit per cycle, using a 4-bit counter for 16 cycles.
  - After the last bit: set `loaded_cfg` ← slot and `loaded_valid` ← 1, then go to VERIFY (macro) or EVAL.
- **EVAL.** Drive the captured address to the LUT and register its output into `resp_result`. Go to RESP.
- **RESP.** `resp_valid` = 1 for exactly one cycle, then return to IDLE.
- **Output holding.** `resp_id`, `resp_result` and `resp_err` hold their values until the next RESP.
- **Config write vs. residency.** A `cfg_we` to slot `loaded_cfg` clears `loaded_valid`.
- **Config write during LOAD.** A `cfg_we` to the slot being loaded restarts the counter at 0 with the new data. The resident-slot clear above does not apply during LOAD.
- **Unchanged request.** A requester keeps its request asserted until it sees `req_ready`. Deasserting earlier is allowed: the request is simply not granted.
- **Reset mid-operation.** Any state returns to IDLE, all outputs go to 0, `loaded_valid` goes to 0, and the LUT cell contents become 0.

## Timing
- **Reset values:** `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_result`=0, `resp_err`=0.
- **Reference edge:** the acceptance edge is E0.
- **Hit:** EVAL in cycle E0..E1, `resp_valid` in cycle E1..E2, giving a latency of 2.
- **Miss:** LOAD for 16 cycles, then EVAL, then RESP, giving a latency of 18; 34 with the macro defined.
- **Throughput:** at most one acceptance every 3 cycles, since IDLE lasts at least 1 cycle.
- **Fairness:** with all requesters continuously valid, grants go 0,1,…,`NREQ`-1,0,…

## Configuration
- **Macro:** `LUT_SCHED_READBACK_EN`.
- **Defined:**
  - Adds the VERIFY state after LOAD: 16 cycles sweeping addresses 0..15 and comparing the LUT output against the slot bits.
  - Any mismatch sets `resp_err`=1 for this response and clears `loaded_valid`.
  - EVAL still runs.
- **Undefined:** no VERIFY state, and `resp_err` is tied to 0.

## Structure
- **Package `lut_sched_pkg`:**
  - state enum `lut_sched_state_t` (IDLE, LOAD, VERIFY, EVAL, RESP);
  - constants `LUT_BITS`=16 and `LUT_AW`=4.
- **Sub-module `lut_cell`:**
  - ports: `clk`, `rst_n`, `shift_en`, `shift_in`, `addr[3:0]`, `dout`;
  - 16-bit shift register with a combinational mux read;
  - reset value 0.

## Test plan
- **Cold miss then hit.**
  - Stimulus: write slot 1 = 16'h8000 (AND4). Requester 0 asks for addr 4'hF, slot 1; then addr 4'h7, slot 1.
  - Response: first `resp_result`=1 after 18 cycles; second `resp_result`=0 after 2 cycles, `resp_id`=0 both times.
- **Round-robin.**
  - Stimulus: all 4 requesters are valid on slot 1.
  - Response: `resp_id` sequence is 0,1,2,3,0 and each response takes 2 cycles.
- **Slot switching.**
  - Stimulus: slot 0 = 16'h6666, slot 1 = 16'h8000. Requester 2 uses slot 0 at addr 1; requester 3 uses slot 1 at addr 1.
  - Response: results are 1 then 0, both misses at 18 cycles.
- **Config-write invalidation.**
  - Stimulus: after slot 1 is resident, write slot 1 = 16'hFFFF, then request addr 0.
  - Response: a miss (18 cycles) with `resp_result`=1.
- **Reset mid-LOAD.**
  - Stimulus: assert `rst_n`=0 at LOAD cycle 7, release, then re-request the same slot.
  - Response: all outputs are 0 during reset, and the re-request is a miss (18 cycles).
- **Readback (macro defined).**
  - Stimulus: a miss on slot 2 = 16'hA5A5 at addr 0.
  - Response: `resp_valid` after 34 cycles with `resp_err`=0 and `resp_result`=1.
